// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, result flags
// and the width helper for the shift/multiply iteration counter.
package alu_pkg;

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_PASS_B = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_NAND   = 3'b100;
    localparam logic [2:0] OP_SHL    = 3'b101;
    localparam logic [2:0] OP_SHR    = 3'b110;
    localparam logic [2:0] OP_MUL    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    // Bits needed to hold an iteration count in the range 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: one-bit-per-cycle logical shifts and shift-add multiply.
// res_* present the state after the current step, so they are final while done is high.
module alu_iter
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi,
    output logic         res_c
);

    localparam int CW = cnt_width(W);

    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          c_q, c_d;
    logic [W-1:0]  addend;
    logic [W:0]    psum;

    assign addend = lo_q[0] ? mcand_q : '0;
    assign psum   = {1'b0, hi_q} + {1'b0, addend};

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        c_d     = c_q;
        if (load) begin
            op_d    = op;
            c_d     = 1'b0;
            mcand_d = a;
            hi_d    = '0;
            if (op == OP_MUL) begin
                lo_d  = b;
                cnt_d = CW'(W);
            end else begin
                lo_d  = a;
                cnt_d = (32'(b) >= 32'(W)) ? CW'(W) : CW'(b);
            end
        end else if (step && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            case (op_q)
                OP_SHL: begin
                    c_d  = lo_q[W-1];
                    lo_d = lo_q << 1;
                end
                OP_SHR: begin
                    c_d  = lo_q[0];
                    lo_d = lo_q >> 1;
                end
                default: begin
                    // Multiplier bits retire from the bottom of lo while product bits enter from the top.
                    hi_d = psum[W:1];
                    lo_d = {psum[0], lo_q[W-1:1]};
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; counters and partial products reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q    <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            c_q     <= c_d;
        end
    end

    assign done   = (cnt_q == CW'(1));
    assign res_lo = lo_d;
    assign res_hi = hi_d;
    assign res_c  = c_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops finish at acceptance,
// shifts and multiply iterate in alu_iter. All outputs come straight from flops.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [W-1:0] y_hi,
    output logic         z,
    output logic         c,
    output logic         n,
    output logic         v
);

    state_e       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] y_hi_q, y_hi_d;
    flags_t       flags_q, flags_d;
    logic         mul_q, mul_d;

    logic [W:0]   sum, diff;
    logic         iter_load, iter_step, iter_done, iter_c;
    logic [W-1:0] iter_lo, iter_hi;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    alu_iter #(.W(W)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load),
        .step   (iter_step),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .res_lo (iter_lo),
        .res_hi (iter_hi),
        .res_c  (iter_c)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        y_hi_d    = y_hi_q;
        flags_d   = flags_q;
        mul_d     = mul_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mul_d   = (op == OP_MUL);
                    y_hi_d  = '0;
                    flags_d = '0;
                    state_d = ST_DONE;
                    case (op)
                        OP_PASS_A: y_d = a;
                        OP_PASS_B: y_d = b;
                        OP_NAND:   y_d = ~(a & b);
                        OP_ADD: begin
                            y_d       = sum[W-1:0];
                            flags_d.c = sum[W];
                            flags_d.v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                        end
                        OP_SUB: begin
                            y_d       = diff[W-1:0];
                            flags_d.c = diff[W];
                            flags_d.v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
                        end
                        OP_SHL, OP_SHR: begin
                            if (b == '0) begin
                                y_d = a;
                            end else begin
                                iter_load = 1'b1;
                                state_d   = ST_BUSY;
                            end
                        end
                        default: begin
                            iter_load = 1'b1;
                            state_d   = ST_BUSY;
                        end
                    endcase
                    if (state_d == ST_DONE) begin
                        flags_d.z = (y_d == '0);
                        flags_d.n = y_d[W-1];
                    end
                end
            end
            ST_BUSY: begin
                iter_step = 1'b1;
                if (iter_done) begin
                    y_d       = iter_lo;
                    y_hi_d    = mul_q ? iter_hi : '0;
                    flags_d.c = mul_q ? (iter_hi != '0) : iter_c;
                    flags_d.v = 1'b0;
                    flags_d.z = (iter_lo == '0);
                    flags_d.n = iter_lo[W-1];
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            y_hi_q  <= '0;
            flags_q <= '0;
            mul_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            flags_q <= flags_d;
            mul_q   <= mul_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign z         = flags_q.z;
    assign c         = flags_q.c;
    assign n         = flags_q.n;
    assign v         = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=4: vector table plus backpressure and mid-operation reset.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y, y_hi;
    logic         z, c, n, v;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [W-1:0] y_hi;
        logic [3:0]   zcnv;
        int           lat;
    } vec_t;

    vec_t vecs[20];

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .z         (z),
        .c         (c),
        .n         (n),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one operation and leave right after the accepting edge, scrambling the operand bus.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = ia;
        b = ib;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 3'($urandom);
    endtask

    // Counts cycles from acceptance to out_valid, bounded; also records whether in_ready rose while waiting.
    task automatic wait_done(output int lat, output bit ready_seen);
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input int idx);
        int    lat;
        bit    rs;
        string tag;
        tag = $sformatf("v%0d", idx);
        issue(vecs[idx].op, vecs[idx].a, vecs[idx].b);
        wait_done(lat, rs);
        check({tag, "_latency"}, 32'(lat), 32'(vecs[idx].lat));
        check({tag, "_in_ready_busy"}, 32'(rs), 32'd0);
        check({tag, "_y"}, 32'(y), 32'(vecs[idx].y));
        check({tag, "_y_hi"}, 32'(y_hi), 32'(vecs[idx].y_hi));
        check({tag, "_zcnv"}, 32'({z, c, n, v}), 32'(vecs[idx].zcnv));
        release_result(tag);
    endtask

    initial begin
        int         lat;
        bit         rs;
        bit         seen;
        logic [W-1:0] held_y;
        logic [3:0] held_f;

        //            op         a      b      y      y_hi   zcnv     lat
        vecs[0]  = '{OP_ADD,    4'd9,  4'd8,  4'd1,  4'd0,  4'b0101, 1};
        vecs[1]  = '{OP_SUB,    4'd3,  4'd5,  4'd14, 4'd0,  4'b0110, 1};
        vecs[2]  = '{OP_SUB,    4'd5,  4'd5,  4'd0,  4'd0,  4'b1000, 1};
        vecs[3]  = '{OP_MUL,    4'd15, 4'd15, 4'd1,  4'd14, 4'b0100, 5};
        vecs[4]  = '{OP_SHL,    4'd6,  4'd2,  4'd8,  4'd0,  4'b0110, 3};
        vecs[5]  = '{OP_SHR,    4'd6,  4'd9,  4'd0,  4'd0,  4'b1000, 5};
        vecs[6]  = '{OP_SHL,    4'd5,  4'd0,  4'd5,  4'd0,  4'b0000, 1};
        vecs[7]  = '{OP_PASS_A, 4'd10, 4'd3,  4'd10, 4'd0,  4'b0010, 1};
        vecs[8]  = '{OP_PASS_B, 4'd10, 4'd3,  4'd3,  4'd0,  4'b0000, 1};
        vecs[9]  = '{OP_NAND,   4'd12, 4'd10, 4'd7,  4'd0,  4'b0000, 1};
        vecs[10] = '{OP_ADD,    4'd7,  4'd1,  4'd8,  4'd0,  4'b0011, 1};
        vecs[11] = '{OP_SUB,    4'd8,  4'd1,  4'd7,  4'd0,  4'b0001, 1};
        vecs[12] = '{OP_MUL,    4'd3,  4'd5,  4'd15, 4'd0,  4'b0010, 5};
        vecs[13] = '{OP_SHR,    4'd9,  4'd1,  4'd4,  4'd0,  4'b0100, 2};
        vecs[14] = '{OP_MUL,    4'd0,  4'd7,  4'd0,  4'd0,  4'b1000, 5};
        vecs[15] = '{OP_SHL,    4'd1,  4'd4,  4'd0,  4'd0,  4'b1100, 5};
        vecs[16] = '{OP_ADD,    4'd15, 4'd1,  4'd0,  4'd0,  4'b1100, 1};
        vecs[17] = '{OP_SHR,    4'd8,  4'd3,  4'd1,  4'd0,  4'b0000, 4};
        vecs[18] = '{OP_MUL,    4'd4,  4'd8,  4'd0,  4'd2,  4'b1100, 5};
        vecs[19] = '{OP_SHL,    4'd15, 4'd3,  4'd8,  4'd0,  4'b0110, 4};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_y_hi", 32'(y_hi), 32'd0);
        check("rst_zcnv", 32'({z, c, n, v}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 20; i++) run_vec(i);

        // Backpressure: result and flags hold while out_ready stays low; new requests are ignored.
        issue(OP_SUB, 4'd3, 4'd5);
        wait_done(lat, rs);
        check("bp_latency", 32'(lat), 32'd1);
        held_y = 4'd14;
        held_f = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = OP_ADD;
            a = 4'd1;
            b = 4'd1;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_y", i), 32'(y), 32'(held_y));
            check($sformatf("bp%0d_zcnv", i), 32'({z, c, n, v}), 32'(held_f));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_ghost_op", 32'(out_valid), 32'd0);

        // Reset in the middle of a multiply discards it.
        issue(OP_MUL, 4'd15, 4'd15);
        @(posedge clk);
        #1;
        check("mr_busy_in_ready", 32'(in_ready), 32'd0);
        check("mr_pre_y", 32'(y), 32'd14);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_y", 32'(y), 32'd0);
        check("mr_async_zcnv", 32'({z, c, n, v}), 32'd0);
        check("mr_async_out_valid", 32'(out_valid), 32'd0);
        check("mr_async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mr_no_out_valid", 32'(seen), 32'd0);
        issue(OP_ADD, 4'd2, 4'd3);
        wait_done(lat, rs);
        check("mr_add_latency", 32'(lat), 32'd1);
        check("mr_add_y", 32'(y), 32'd5);
        check("mr_add_zcnv", 32'({z, c, n, v}), 32'b0000);
        release_result("mr_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 4, SHALL set the operand/result width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and opcode valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 a, b  input  W each  operands, unsigned; signed view used only for V.
REQ-007 op  input  3  opcode: 000 pass A, 001 A-B, 010 pass B, 011 A+B, 100 NAND, 101 SHL A by B, 110 SHR (logical) A by B, 111 MUL A*B.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 y  output  W  result, low W bits.
REQ-011 y_hi  output  W  upper W bits of MUL product; 0 for every other op.
REQ-012 z, c, n, v  output  1 each  zero, carry/borrow, negative, signed overflow.

Function
REQ-013 FSM SHALL have states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Acceptance SHALL occur on a rising edge with in_valid && in_ready; a, b, op SHALL be captured then and ignored afterwards.
REQ-015 Ops 000-100 SHALL be computed at acceptance, IDLE->DONE; out_valid high the next cycle (latency 1).
REQ-016 SHL/SHR: count k = min(b, W); k=0 SHALL go IDLE->DONE with y=a; else IDLE->BUSY, one bit per cycle, DONE after exactly k BUSY cycles.
REQ-017 MUL SHALL be shift-add, exactly W BUSY cycles, then DONE; {y_hi,y} = a*b, full 2W bits.
REQ-018 In DONE, y, y_hi, flags SHALL hold stable until out_ready; DONE&&out_ready SHALL go to IDLE (no accept in the same cycle).
REQ-019 in_valid while not IDLE SHALL be ignored; in_ready SHALL not depend on out_ready.
REQ-020 z = (y == 0), all ops, y_hi excluded.
REQ-021 n = y[W-1], all ops.
REQ-022 c: ADD = carry out of bit W-1; SUB = borrow (1 when a<b unsigned); SHL/SHR = last bit shifted out (0 when k=0); MUL = (y_hi != 0); all other ops 0.
REQ-023 v: ADD/SUB = two's-complement overflow of W-bit result; all other ops 0.
REQ-024 NAND SHALL be bitwise ~(a&b) over W bits; pass ops SHALL set y to a or b unchanged.
REQ-025 Shift with b>=W SHALL give y=0 and c = last bit shifted out after W shifts.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE; y, y_hi, z, c, n, v = 0; out_valid=0; in_ready=1 from the first edge after release.
REQ-027 Reset during BUSY or DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-028 Iteration counters and partial products SHALL also reset to 0.

Structure
REQ-029 Package alu_pkg SHALL hold opcode constants, the state enum, and the W-derived counter width function.
REQ-030 Iterative shift/multiply datapath SHALL be one sub-module alu_iter (load, step, done), instantiated once; single-cycle ops stay in alu_seq.
REQ-031 No combinational path SHALL exist from in_valid/out_ready to y or flags.

Verification (W=4)
REQ-032 ADD a=9, b=8 -> one cycle after accept: y=1, c=1, v=1, n=0, z=0.
REQ-033 SUB a=3, b=5 -> y=14, c=1, n=1, v=0, z=0; SUB a=5, b=5 -> y=0, z=1, c=0.
REQ-034 MUL a=15, b=15 -> out_valid 5 cycles after accept; y=1, y_hi=14, c=1; in_ready low throughout.
REQ-035 SHL a=6, b=2 -> y=8, c=1 after 3 cycles; SHR a=6, b=9 -> y=0, after W+1 cycles; SHL b=0 -> y=a, c=0, latency 1.
REQ-036 Backpressure: out_ready low 3 cycles in DONE -> y/flags unchanged, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-037 rst_n pulsed low mid-MUL -> outputs 0 asynchronously, no out_valid for that op; next ADD 2+3 -> y=5.
